// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: command front-end for the PWM / H-bridge stage.
//
// Accepts speed/direction/brake commands over a valid/ready handshake and
// produces a ramped duty, the current direction and a brake flag for the PWM
// stage. Duty moves toward the stored target by STEP once every RAMP_DIV
// cycles. A direction reversal first ramps duty down to zero. A brake command
// forces duty to zero and holds off new commands for BRAKE_HOLD cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command can be accepted this cycle
//   cmd_speed  in   target duty, clamped to PERIOD
//   cmd_dir    in   target direction (1 = clockwise)
//   cmd_brake  in   brake request, overrides speed/dir
//   period     out  constant PWM period
//   dutyCycle  out  current ramped duty
//   direction  out  current direction
//   motorbrake out  brake active
//   busy       out  ramping or reversing
module motor_ramp_ctrl #(
    parameter int unsigned PERIOD     = 100,
    parameter int unsigned RAMP_DIV   = 1000,
    parameter int unsigned STEP       = 1,
    parameter int unsigned BRAKE_HOLD = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_speed,
    input  logic       cmd_dir,
    input  logic       cmd_brake,
    output logic [7:0] period,
    output logic [7:0] dutyCycle,
    output logic       direction,
    output logic       motorbrake,
    output logic       busy
);

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned BW = (BRAKE_HOLD > 1) ? $clog2(BRAKE_HOLD) : 1;

    localparam logic [7:0]    PERIOD_B   = 8'(PERIOD);
    localparam logic [7:0]    STEP_B     = 8'(STEP);
    localparam logic [8:0]    STEP_W     = 9'(STEP);
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [BW-1:0] HOLD_LOAD  = BW'(BRAKE_HOLD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRamp,
        StHold,
        StReverse,
        StBrake
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          brake_q, brake_d;
    logic [7:0]    tgt_q, tgt_d;
    logic          tgt_dir_q, tgt_dir_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;

    logic       accept;
    logic       tick;
    logic [7:0] cmd_tgt;
    logic [8:0] up_sum;
    logic [8:0] dn_lim;
    logic [7:0] step_up;
    logic [7:0] step_dn;
    logic [7:0] ramp_next;
    logic [7:0] rev_next;

    assign accept  = cmd_valid & ready_q;
    assign tick    = (presc_q == PRESC_LAST);
    assign cmd_tgt = (cmd_speed > PERIOD_B) ? PERIOD_B : cmd_speed;

    // Step arithmetic is done at 9 bits so a large STEP can never wrap duty;
    // every step saturates exactly at the target.
    assign up_sum    = {1'b0, duty_q} + STEP_W;
    assign dn_lim    = {1'b0, tgt_q} + STEP_W;
    assign step_up   = (up_sum >= {1'b0, tgt_q}) ? tgt_q : up_sum[7:0];
    assign step_dn   = ({1'b0, duty_q} >= dn_lim) ? (duty_q - STEP_B) : tgt_q;
    assign ramp_next = (duty_q < tgt_q) ? step_up : step_dn;
    assign rev_next  = ({1'b0, duty_q} > STEP_W) ? (duty_q - STEP_B) : 8'd0;

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dir_d     = dir_q;
        brake_d   = brake_q;
        tgt_d     = tgt_q;
        tgt_dir_d = tgt_dir_q;
        presc_d   = presc_q;
        bcnt_d    = bcnt_q;
        ready_d   = 1'b1;

        if (accept) begin
            // A command always wins over a coincident ramp tick.
            presc_d = '0;
            if (cmd_brake) begin
                state_d   = StBrake;
                duty_d    = 8'd0;
                brake_d   = 1'b1;
                bcnt_d    = HOLD_LOAD;
                ready_d   = 1'b0;
                tgt_d     = 8'd0;
                tgt_dir_d = dir_q;
            end else begin
                brake_d   = 1'b0;
                tgt_d     = cmd_tgt;
                tgt_dir_d = cmd_dir;
                if ((cmd_dir != dir_q) && (duty_q != 8'd0)) begin
                    state_d = StReverse;
                end else begin
                    // Only differs from dir_q here when duty is already zero.
                    dir_d = cmd_dir;
                    if (cmd_tgt == duty_q) begin
                        state_d = (cmd_tgt == 8'd0) ? StIdle : StHold;
                    end else begin
                        state_d = StRamp;
                    end
                end
            end
        end else begin
            unique case (state_q)
                StRamp: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        duty_d = ramp_next;
                        if (ramp_next == tgt_q) begin
                            state_d = (tgt_q == 8'd0) ? StIdle : StHold;
                        end
                    end
                end
                StReverse: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick) begin
                        duty_d = rev_next;
                        if (rev_next == 8'd0) begin
                            dir_d   = tgt_dir_q;
                            state_d = (tgt_q != 8'd0) ? StRamp : StIdle;
                        end
                    end
                end
                StBrake: begin
                    if (bcnt_q != '0) begin
                        bcnt_d = bcnt_q - BW'(1);
                    end
                    // Ready rises the cycle after the counter has reached zero.
                    ready_d = (bcnt_q == '0);
                end
                StIdle, StHold: begin
                end
            endcase
        end

        busy_d = (state_d == StRamp) || (state_d == StReverse);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            duty_q    <= 8'd0;
            dir_q     <= 1'b1;
            brake_q   <= 1'b0;
            tgt_q     <= 8'd0;
            tgt_dir_q <= 1'b1;
            presc_q   <= '0;
            bcnt_q    <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            dir_q     <= dir_d;
            brake_q   <= brake_d;
            tgt_q     <= tgt_d;
            tgt_dir_q <= tgt_dir_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign period     = PERIOD_B;
    assign dutyCycle  = duty_q;
    assign direction  = dir_q;
    assign motorbrake = brake_q;
    assign busy       = busy_q;
    assign cmd_ready  = ready_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

    localparam int PERIOD     = 100;
    localparam int RAMP_DIV   = 4;
    localparam int STEP       = 10;
    localparam int BRAKE_HOLD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_speed = 8'd0;
    logic       cmd_dir = 1'b0;
    logic       cmd_brake = 1'b0;
    logic       cmd_ready;
    logic [7:0] period;
    logic [7:0] dutyCycle;
    logic       direction;
    logic       motorbrake;
    logic       busy;

    motor_ramp_ctrl #(
        .PERIOD    (PERIOD),
        .RAMP_DIV  (RAMP_DIV),
        .STEP      (STEP),
        .BRAKE_HOLD(BRAKE_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_speed (cmd_speed),
        .cmd_dir   (cmd_dir),
        .cmd_brake (cmd_brake),
        .period    (period),
        .dutyCycle (dutyCycle),
        .direction (direction),
        .motorbrake(motorbrake),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Expected output changes: duty, direction, and the edge they appear on (-1 = any).
    typedef struct {
        int duty;
        int dir;
        int cyc;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        int speed;
        int dir;
        int fduty;
        int fdir;
    } vec_t;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int d, input int dr, input int c);
        ev_t e;
        e.duty = d;
        e.dir  = dr;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    // Monitor: every change of duty or direction must match the head of the scoreboard.
    bit         mon_en = 1'b0;
    logic [7:0] prev_duty;
    logic       prev_dir;
    ev_t        mon_ev;
    always @(negedge clk) begin
        if (mon_en && (dutyCycle !== prev_duty || direction !== prev_dir)) begin
            if (direction !== prev_dir) chk("dir_change_duty_zero", int'(dutyCycle), 0);
            if (sb.size() == 0) begin
                chk("unexpected_duty", int'(dutyCycle), int'(prev_duty));
                chk("unexpected_dir", int'(direction), int'(prev_dir));
            end else begin
                mon_ev = sb.pop_front();
                chk("sb_duty", int'(dutyCycle), mon_ev.duty);
                chk("sb_dir", int'(direction), mon_ev.dir);
                if (mon_ev.cyc >= 0) chk("sb_cycle", cyc, mon_ev.cyc);
            end
        end
        prev_duty = dutyCycle;
        prev_dir  = direction;
    end

    // Reference trajectory for a non-brake command issued at edge acc.
    task automatic plan(input int cur_d, input int cur_dir, input int spd, input int dr,
                        input int acc, output int t_end);
        int tgt;
        int d;
        int t;
        tgt = (spd > PERIOD) ? PERIOD : spd;
        d   = cur_d;
        t   = acc;
        if (dr != cur_dir) begin
            if (d == 0) begin
                push(0, dr, acc);
            end else begin
                while (d > 0) begin
                    t += RAMP_DIV;
                    d = (d > STEP) ? d - STEP : 0;
                    push(d, (d == 0) ? dr : cur_dir, t);
                end
            end
        end
        while (d != tgt) begin
            t += RAMP_DIV;
            if (d < tgt) d = (d + STEP >= tgt) ? tgt : d + STEP;
            else d = (d >= tgt + STEP) ? d - STEP : tgt;
            push(d, dr, t);
        end
        t_end = t;
    endtask

    task automatic send(input int spd, input bit dr, input bit brk, output int acc);
        @(negedge clk);
        cmd_speed = 8'(spd);
        cmd_dir   = dr;
        cmd_brake = brk;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100 && cmd_ready !== 1'b1; i++) @(negedge clk);
        if (cmd_ready !== 1'b1) chk("send_ready_timeout", int'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_until(input int t);
        for (int i = 0; i < 2000 && cyc < t; i++) @(negedge clk);
        if (cyc < t) chk("wait_until_timeout", cyc, t);
    endtask

    task automatic wait_duty(input int v);
        for (int i = 0; i < 200 && int'(dutyCycle) != v; i++) @(negedge clk);
        chk("wait_duty", int'(dutyCycle), v);
    endtask

    // Counts ready-low samples, starting at the negedge the caller is on.
    task automatic count_ready_low(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (cmd_ready === 1'b1) break;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_duty"}, int'(dutyCycle), 0);
        chk({tag, "_dir"}, int'(direction), 1);
        chk({tag, "_brake"}, int'(motorbrake), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        chk({tag, "_period"}, int'(period), PERIOD);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   acc;
        int   acc2;
        int   t_end;
        int   n;
        int   cur_d;
        int   cur_dir;

        vecs[0] = '{35, 1, 35, 1};    // ramp up 10,20,30,35
        vecs[1] = '{20, 0, 20, 0};    // reverse 25,15,5,0 then 10,20
        vecs[2] = '{0, 0, 0, 0};      // same-dir ramp down to idle
        vecs[3] = '{200, 1, 100, 1};  // clamp at PERIOD, flip at zero duty
        vecs[4] = '{100, 1, 100, 1};  // target equals duty: stays in hold
        vecs[5] = '{95, 1, 95, 1};    // downward step saturates at target
        vecs[6] = '{0, 0, 0, 0};      // reverse all the way down to idle

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");
        mon_en = 1'b1;

        cur_d   = 0;
        cur_dir = 1;
        for (int k = 0; k < 7; k++) begin
            send(vecs[k].speed, vecs[k].dir[0], 1'b0, acc);
            plan(cur_d, cur_dir, vecs[k].speed, vecs[k].dir, acc, t_end);
            @(negedge clk);
            chk($sformatf("vec%0d_busy_start", k), int'(busy), (vecs[k].fduty != cur_d) ? 1 : 0);
            wait_until(t_end + 2);
            chk($sformatf("vec%0d_final_duty", k), int'(dutyCycle), vecs[k].fduty);
            chk($sformatf("vec%0d_final_dir", k), int'(direction), vecs[k].fdir);
            chk($sformatf("vec%0d_final_busy", k), int'(busy), 0);
            cur_d   = vecs[k].fduty;
            cur_dir = vecs[k].fdir;
        end

        // Brake mid-ramp at duty 40, with a command held pending through the hold.
        send(60, 1'b1, 1'b0, acc);
        push(0, 1, acc);
        for (int j = 1; j <= 4; j++) push(10 * j, 1, acc + RAMP_DIV * j);
        wait_duty(40);
        send(0, 1'b1, 1'b1, acc);
        push(0, 1, acc);
        @(negedge clk);
        chk("brake_flag", int'(motorbrake), 1);
        chk("brake_busy", int'(busy), 0);
        cmd_speed = 8'd30;
        cmd_dir   = 1'b0;
        cmd_brake = 1'b0;
        cmd_valid = 1'b1;
        count_ready_low(n);
        chk("brake_ready_low_cycles", n, BRAKE_HOLD);
        acc2 = cyc + 1;
        push(0, 0, acc2);
        for (int j = 1; j <= 3; j++) push(10 * j, 0, acc2 + RAMP_DIV * j);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("release_brake_flag", int'(motorbrake), 0);
        chk("release_dir", int'(direction), 0);
        wait_until(acc2 + 3 * RAMP_DIV + 2);
        chk("release_duty", int'(dutyCycle), 30);
        chk("release_busy", int'(busy), 0);

        // Brake, then a second brake after expiry reloads the hold.
        send(0, 1'b0, 1'b1, acc);
        push(0, 0, acc);
        @(negedge clk);
        count_ready_low(n);
        chk("brake2_ready_low_cycles", n, BRAKE_HOLD);
        send(50, 1'b0, 1'b1, acc);
        @(negedge clk);
        chk("reload_duty", int'(dutyCycle), 0);
        chk("reload_brake", int'(motorbrake), 1);
        count_ready_low(n);
        chk("reload_ready_low_cycles", n, BRAKE_HOLD);
        send(0, 1'b0, 1'b0, acc);
        @(negedge clk);
        chk("idle_after_brake", int'(motorbrake), 0);

        // Command landing on a tick edge discards that tick's step.
        send(35, 1'b1, 1'b0, acc);
        push(0, 1, acc);
        push(10, 1, acc + RAMP_DIV);
        wait_until(acc + 2 * RAMP_DIV - 2);
        send(35, 1'b1, 1'b0, acc2);
        push(20, 1, acc2 + RAMP_DIV);
        push(30, 1, acc2 + 2 * RAMP_DIV);
        push(35, 1, acc2 + 3 * RAMP_DIV);
        wait_until(acc2 + 3 * RAMP_DIV + 2);

        // Reset asserted during a reversal at duty 15.
        send(20, 1'b0, 1'b0, acc);
        push(25, 1, acc + RAMP_DIV);
        push(15, 1, acc + 2 * RAMP_DIV);
        wait_duty(15);
        reset = 1'b1;
        push(0, 1, -1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("midrev_reset");
        repeat (3 * RAMP_DIV) @(negedge clk);
        chk("post_reset_idle_duty", int'(dutyCycle), 0);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
